grf_wb_ctrl: RTL and testbench
==============================

# grf_wb_ctrl

Write-back port controller for the GRF. It sequences the single GRF write port between the pipeline W stage and the multi-cycle MDU, whose results complete out of band. It drives the 3-bit write-data select of the W-stage write-data mux and holds MDU results in a small FIFO until the port is free. When an MDU result waits too long, it stalls the pipeline to force a free cycle. It also reports pending-destination hazards to the D-stage stall logic.

## Interface
Parameters:
- `DEPTH`, 2: MDU result FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 4: cycles a FIFO head may wait before a forced drain.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low (reset when 0 at a rising edge).
- `w_valid` in 1: W-stage instruction writes the GRF.
- `w_a3` in 5: W-stage destination register.
- `w_src` in 2: W data source: 0 ALU, 1 DM, 2 PC+8, 3 CP0.
- `md_req` in 1: MDU result ready.
- `md_a3` in 5: MDU destination register.
- `md_data` in 32: MDU result.
- `md_ack` out 1: MDU result accepted this cycle.
- `grfwd_op` out 3: mux select, `{1'b0, w_src}`.
- `grf_we` out 1: GRF write enable.
- `grf_a3` out 5: GRF write address.
- `grf_md_sel` out 1: 1 selects `grf_md_data` instead of the mux output.
- `grf_md_data` out 32: MDU data to write.
- `stall_req` out 1: freeze pipeline (F/D/E/M hold, W bubble).
- `q_rs` / `q_rt` in 5: D-stage source registers.
- `q_rs_busy` / `q_rt_busy` out 1: the source matches a valid FIFO entry.

## Operation
- **Port ownership.** The W stage "claims" the port when `w_valid && w_a3 != 0`. The W stage always has priority.
- **W write.** When the W stage claims: `grf_we=1`, `grf_a3=w_a3`, `grf_md_sel=0`.
- **MDU drain.** Otherwise, if the FIFO is non-empty, write the head: `grf_we=1`, `grf_a3=head.a3`, `grf_md_sel=1`, `grf_md_data=head.data`, and pop.
- **MDU bypass.** Otherwise, if `md_req` is high and the FIFO is empty, write `md_data` directly (bypass) and assert `md_ack`. Nothing is enqueued.
- **Enqueue.** In all other cases, `md_ack = md_req && !full`, and an acked request is enqueued.
  - A simultaneous pop and push is allowed when the FIFO is full.
  - Entries with `md_a3==0` are acked and discarded.
- **Idle port.** With no source writing, `grf_we=0`, `grf_a3=0`, `grf_md_sel=0`.
- **WAW kill.** An MDU result is always older than the W instruction.
  - When the W stage claims register r, every valid FIFO entry with a3==r is invalidated in the same cycle.
  - A same-cycle `md_req` with `md_a3==r` is acked and dropped.
  - Invalid entries at the head are popped without writing and do not occupy the port.
- **Hazard query.** `q_x_busy` is combinational: true if any valid entry has a3==`q_x` and `q_x` != 0.
- **FSM** (registered state; `starve_cnt` is a 3-bit counter):
  - IDLE: FIFO empty. Go to WAIT on enqueue.
  - WAIT: `starve_cnt` increments each cycle the head is blocked by a W claim and resets on pop.
    - Go to FORCE when `starve_cnt==STARVE_LIMIT-1` and the head is blocked again.
    - Go to IDLE when the FIFO empties.
  - FORCE: `stall_req=1`. The next W stage is a bubble, so the head drains.
    - Go to WAIT (count>0) or IDLE after the pop; `starve_cnt` clears.
- `stall_req` is a Moore output: 1 only in FORCE.

## Timing
- Reset (`reset==0` at an edge): FIFO empty, all valids 0, state IDLE, `starve_cnt=0`.
  - Outputs in the following cycle: `stall_req=0`, `grf_we=0`, `md_ack=0`, `q_*_busy=0`, `grfwd_op={1'b0,w_src}`.
  - Reset mid-operation discards buffered results without writing them.
- `grf_we`, `grf_a3`, `grf_md_sel`, `grf_md_data`, `md_ack` and `grfwd_op` are combinational. The GRF samples them at the same edge.
- Bypass latency is 0 cycles. Enqueued latency is at least 1 cycle.
- Worst-case FIFO residency is STARVE_LIMIT+1 cycles per entry ahead of it.
- The MDU holds `md_req`/`md_a3`/`md_data` stable until `md_ack`.

## Structure
- Shared package `mips_pkg`:
  - `GRFWD_ALU=0`, `GRFWD_DM=1`, `GRFWD_PC8=2`, `GRFWD_CP0=3`.
  - The `wbc_state_t` enum {IDLE, WAIT, FORCE}.
- One sub-module, `md_wb_fifo`: DEPTH-entry FIFO with a per-entry valid bit, a per-entry match-and-kill port, and two lookup ports.
- FSM and port mux live in `grf_wb_ctrl`.

## Test plan
- **Bypass.** Empty FIFO, `w_valid=0`, `md_req=1`, `md_a3=5`, `md_data=0x1234`.
  - Expect `grf_we=1`, `grf_a3=5`, `grf_md_sel=1`, `md_ack=1` in the same cycle.
  - FIFO stays empty.
- **Enqueue then drain.** `w_valid=1` (`w_a3=3`, `w_src=2`) with `md_req` (`md_a3=7`).
  - Expect `grfwd_op=2`, `grf_a3=3`, `md_ack=1`, `q_rs=7` gives busy.
  - Next cycle, `w_valid=0`: expect `grf_a3=7`, `grf_md_sel=1`, busy clears.
- **Forced drain.** One entry queued and `w_valid=1` (`w_a3≠0`) every cycle.
  - Expect `stall_req=1` after 4 blocked cycles.
  - Bubble cycle writes the entry; `stall_req` drops the next cycle.
- **WAW kill.** Entry for r9 queued; W writes r9.
  - Expect the entry invalidated, never written, and `q_rt=9` not busy afterward.
- **Full/backpressure.** DEPTH entries queued and W busy.
  - Expect `md_req` held with `md_ack=0`.
  - The cycle the head drains, `md_ack=1` (simultaneous pop and push).
- **Reset.** Drive `reset=0` with 2 entries queued in FORCE.
  - Expect the FIFO empty, `stall_req=0`, and no MDU write after reset.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS core slice.
//   GRFWD_*     : W-stage write-data mux selects (low two bits of grfwd_op).
//   wbc_state_t : write-back port controller FSM states.
package mips_pkg;

   localparam logic [1:0] GRFWD_ALU = 2'd0;
   localparam logic [1:0] GRFWD_DM  = 2'd1;
   localparam logic [1:0] GRFWD_PC8 = 2'd2;
   localparam logic [1:0] GRFWD_CP0 = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FORCE
   } wbc_state_t;

endpackage

// File: rtl/md_wb_fifo.sv
// md_wb_fifo: DEPTH-entry queue of MDU results awaiting the GRF write port.
//   clk, reset          : clock, synchronous active-low reset
//   push/push_a3/_data  : enqueue an entry (caller guarantees not full unless popping)
//   pop                 : drop the head entry, valid or not
//   kill/kill_a3        : invalidate every valid entry whose a3 matches
//   q_rs/q_rt           : lookup registers; rs_hit/rt_hit flag a valid match
//   empty/full/count    : occupancy, including invalidated entries
//   head_v/_a3/_data    : head entry contents
module md_wb_fifo #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [4:0]               push_a3,
   input  logic [31:0]              push_data,
   input  logic                     pop,
   input  logic                     kill,
   input  logic [4:0]               kill_a3,
   input  logic [4:0]               q_rs,
   input  logic [4:0]               q_rt,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     head_v,
   output logic [4:0]               head_a3,
   output logic [31:0]              head_data,
   output logic                     rs_hit,
   output logic                     rt_hit
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DEPTH-1:0] v_q, v_d;
   logic [4:0]       a3_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [AW:0]      cnt_q;

   // Kill first, then pop clears, then push sets: when full with pop and push
   // on the same slot the new entry must survive.
   always_comb begin
      v_d = v_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (kill && (a3_q[i] == kill_a3)) v_d[i] = 1'b0;
      end
      if (pop)  v_d[rd_q] = 1'b0;
      if (push) v_d[wr_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         v_q   <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         v_q   <= v_d;
         if (pop)  rd_q <= rd_q + 1'b1;
         if (push) wr_q <= wr_q + 1'b1;
         cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   // Payload needs no reset; valid bits gate all use of it.
   always_ff @(posedge clk) begin
      if (push) begin
         a3_q[wr_q]   <= push_a3;
         data_q[wr_q] <= push_data;
      end
   end

   always_comb begin
      rs_hit = 1'b0;
      rt_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (v_q[i] && (a3_q[i] == q_rs)) rs_hit = 1'b1;
         if (v_q[i] && (a3_q[i] == q_rt)) rt_hit = 1'b1;
      end
      if (q_rs == 5'd0) rs_hit = 1'b0;
      if (q_rt == 5'd0) rt_hit = 1'b0;
   end

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == (AW + 1)'(DEPTH));
   assign count     = cnt_q;
   assign head_v    = v_q[rd_q];
   assign head_a3   = a3_q[rd_q];
   assign head_data = data_q[rd_q];

endmodule

// File: rtl/grf_wb_ctrl.sv
// grf_wb_ctrl: arbitrates the single GRF write port between the W stage and
// out-of-band MDU results, buffering MDU results and forcing a pipeline
// bubble when a buffered result has waited too long.
//   clk, reset                  : clock, synchronous active-low reset
//   w_valid/w_a3/w_src          : W-stage write request and data source
//   md_req/md_a3/md_data/md_ack : MDU result handshake
//   grfwd_op                    : W-stage write-data mux select
//   grf_we/grf_a3               : GRF write enable and address
//   grf_md_sel/grf_md_data      : select MDU data instead of the mux output
//   stall_req                   : freeze F/D/E/M, bubble W
//   q_rs/q_rt, q_rs_busy/_busy  : D-stage pending-destination lookups
module grf_wb_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        w_valid,
   input  logic [4:0]  w_a3,
   input  logic [1:0]  w_src,
   input  logic        md_req,
   input  logic [4:0]  md_a3,
   input  logic [31:0] md_data,
   output logic        md_ack,
   output logic [2:0]  grfwd_op,
   output logic        grf_we,
   output logic [4:0]  grf_a3,
   output logic        grf_md_sel,
   output logic [31:0] grf_md_data,
   output logic        stall_req,
   input  logic [4:0]  q_rs,
   input  logic [4:0]  q_rt,
   output logic        q_rs_busy,
   output logic        q_rt_busy
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [2:0]  LAST_WAIT = 3'(STARVE_LIMIT - 1);

   wbc_state_t  state_q, state_d;
   logic [2:0]  starve_cnt_q, starve_cnt_d;

   logic        f_empty, f_full, f_head_v;
   logic [AW:0] f_count, count_nxt;
   logic [4:0]  f_head_a3;
   logic [31:0] f_head_data;

   logic claim, head_live, drain, pop, bypass, push, blocked;

   assign claim     = w_valid && (w_a3 != 5'd0);
   assign head_live = !f_empty && f_head_v;
   assign drain     = !claim && head_live;
   // A killed head is discarded without using the port.
   assign pop       = (!f_empty && !f_head_v) || drain;
   assign bypass    = !claim && f_empty && md_req;
   assign md_ack    = md_req && (!f_full || pop);
   // r0 results and results overwritten by the current W write are acked and dropped.
   assign push      = md_ack && !bypass && (md_a3 != 5'd0) && !(claim && (md_a3 == w_a3));
   assign blocked   = claim && head_live;
   assign count_nxt = f_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

   md_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_a3   (md_a3),
      .push_data (md_data),
      .pop       (pop),
      .kill      (claim),
      .kill_a3   (w_a3),
      .q_rs      (q_rs),
      .q_rt      (q_rt),
      .empty     (f_empty),
      .full      (f_full),
      .count     (f_count),
      .head_v    (f_head_v),
      .head_a3   (f_head_a3),
      .head_data (f_head_data),
      .rs_hit    (q_rs_busy),
      .rt_hit    (q_rt_busy)
   );

   assign grfwd_op = {1'b0, w_src};

   always_comb begin
      grf_we      = 1'b0;
      grf_a3      = 5'd0;
      grf_md_sel  = 1'b0;
      grf_md_data = md_data;
      if (claim) begin
         grf_we = 1'b1;
         grf_a3 = w_a3;
      end else if (head_live) begin
         grf_we      = 1'b1;
         grf_a3      = f_head_a3;
         grf_md_sel  = 1'b1;
         grf_md_data = f_head_data;
      end else if (bypass && (md_a3 != 5'd0)) begin
         grf_we     = 1'b1;
         grf_a3     = md_a3;
         grf_md_sel = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      unique case (state_q)
         IDLE: begin
            starve_cnt_d = 3'd0;
            if (push) state_d = WAIT;
         end
         WAIT: begin
            if (pop) begin
               starve_cnt_d = 3'd0;
               if (count_nxt == '0) state_d = IDLE;
            end else if (blocked) begin
               if (starve_cnt_q == LAST_WAIT) state_d = FORCE;
               else starve_cnt_d = starve_cnt_q + 3'd1;
            end
         end
         FORCE: begin
            // Hold the stall until the bubble lets the head drain.
            if (pop) begin
               starve_cnt_d = 3'd0;
               state_d      = (count_nxt != '0) ? WAIT : IDLE;
            end
         end
         default: begin
            state_d      = IDLE;
            starve_cnt_d = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         starve_cnt_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign stall_req = (state_q == FORCE);

endmodule

// File: tb/tb_grf_wb_ctrl.sv
// tb_grf_wb_ctrl: directed-vector bench for grf_wb_ctrl (DEPTH=2, STARVE_LIMIT=4).
// Inputs change and outputs are checked just after the falling edge.
module tb_grf_wb_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        w_valid;
   logic [4:0]  w_a3;
   logic [1:0]  w_src;
   logic        md_req;
   logic [4:0]  md_a3;
   logic [31:0] md_data;
   logic        md_ack;
   logic [2:0]  grfwd_op;
   logic        grf_we;
   logic [4:0]  grf_a3;
   logic        grf_md_sel;
   logic [31:0] grf_md_data;
   logic        stall_req;
   logic [4:0]  q_rs, q_rt;
   logic        q_rs_busy, q_rt_busy;

   int errors = 0;
   int checks = 0;

   grf_wb_ctrl #(
      .DEPTH        (2),
      .STARVE_LIMIT (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .w_valid     (w_valid),
      .w_a3        (w_a3),
      .w_src       (w_src),
      .md_req      (md_req),
      .md_a3       (md_a3),
      .md_data     (md_data),
      .md_ack      (md_ack),
      .grfwd_op    (grfwd_op),
      .grf_we      (grf_we),
      .grf_a3      (grf_a3),
      .grf_md_sel  (grf_md_sel),
      .grf_md_data (grf_md_data),
      .stall_req   (stall_req),
      .q_rs        (q_rs),
      .q_rt        (q_rt),
      .q_rs_busy   (q_rs_busy),
      .q_rt_busy   (q_rt_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      reset   = 1'b0;
      w_valid = 1'b0;
      w_a3    = 5'd0;
      w_src   = 2'd0;
      md_req  = 1'b0;
      md_a3   = 5'd0;
      md_data = 32'd0;
      q_rs    = 5'd5;
      q_rt    = 5'd7;
      repeat (2) @(posedge clk);

      // Reset state
      next_cycle();
      w_src = 2'd3;
      #1;
      check("rst_stall", stall_req, 0);
      check("rst_we", grf_we, 0);
      check("rst_ack", md_ack, 0);
      check("rst_rs_busy", q_rs_busy, 0);
      check("rst_rt_busy", q_rt_busy, 0);
      check("rst_grfwd", grfwd_op, 3);

      // Bypass: empty FIFO, W idle
      next_cycle();
      reset = 1'b1; w_src = 2'd0;
      md_req = 1'b1; md_a3 = 5'd5; md_data = 32'h1234;
      #1;
      check("byp_we", grf_we, 1);
      check("byp_a3", grf_a3, 5);
      check("byp_sel", grf_md_sel, 1);
      check("byp_data", grf_md_data, 32'h1234);
      check("byp_ack", md_ack, 1);
      next_cycle();
      md_req = 1'b0;
      #1;
      check("byp_empty_busy", q_rs_busy, 0);
      check("byp_after_we", grf_we, 0);

      // Enqueue behind a W write, then drain
      next_cycle();
      w_valid = 1'b1; w_a3 = 5'd3; w_src = 2'd2;
      md_req = 1'b1; md_a3 = 5'd7; md_data = 32'hAAAA;
      #1;
      check("enq_grfwd", grfwd_op, 2);
      check("enq_a3", grf_a3, 3);
      check("enq_sel", grf_md_sel, 0);
      check("enq_ack", md_ack, 1);
      next_cycle();
      w_valid = 1'b0; md_req = 1'b0; q_rs = 5'd7;
      #1;
      check("drn_busy", q_rs_busy, 1);
      check("drn_we", grf_we, 1);
      check("drn_a3", grf_a3, 7);
      check("drn_sel", grf_md_sel, 1);
      check("drn_data", grf_md_data, 32'hAAAA);
      next_cycle();
      #1;
      check("drn_busy_clr", q_rs_busy, 0);
      check("drn_idle_we", grf_we, 0);

      // Forced drain after 4 blocked cycles
      next_cycle();
      w_valid = 1'b1; w_a3 = 5'd4; w_src = 2'd0;
      md_req = 1'b1; md_a3 = 5'd10; md_data = 32'hBEEF;
      #1;
      check("frc_enq_ack", md_ack, 1);
      for (int i = 1; i <= 4; i++) begin
         next_cycle();
         md_req = 1'b0;
         #1;
         check($sformatf("frc_wait%0d_stall", i), stall_req, 0);
         check($sformatf("frc_wait%0d_a3", i), grf_a3, 4);
      end
      next_cycle();
      #1;
      check("frc_stall", stall_req, 1);
      check("frc_hold_a3", grf_a3, 4);
      next_cycle();
      w_valid = 1'b0;
      #1;
      check("frc_bubble_stall", stall_req, 1);
      check("frc_bubble_we", grf_we, 1);
      check("frc_bubble_a3", grf_a3, 10);
      check("frc_bubble_sel", grf_md_sel, 1);
      check("frc_bubble_data", grf_md_data, 32'hBEEF);
      next_cycle();
      #1;
      check("frc_release", stall_req, 0);
      check("frc_release_we", grf_we, 0);

      // WAW kill of a queued entry
      next_cycle();
      w_valid = 1'b1; w_a3 = 5'd1;
      md_req = 1'b1; md_a3 = 5'd9; md_data = 32'h99;
      #1;
      check("waw_enq_ack", md_ack, 1);
      next_cycle();
      md_req = 1'b0; w_a3 = 5'd9; q_rt = 5'd9;
      #1;
      check("waw_busy_before", q_rt_busy, 1);
      check("waw_w_a3", grf_a3, 9);
      check("waw_w_sel", grf_md_sel, 0);
      next_cycle();
      w_valid = 1'b0;
      #1;
      check("waw_busy_after", q_rt_busy, 0);
      check("waw_no_write", grf_we, 0);
      next_cycle();
      md_req = 1'b1; md_a3 = 5'd2; md_data = 32'h22;
      #1;
      check("waw_empty_bypass", grf_md_sel, 1);
      // Same-cycle MDU result to the W destination is acked and dropped
      next_cycle();
      w_valid = 1'b1; w_a3 = 5'd12; md_a3 = 5'd12; md_data = 32'h12;
      #1;
      check("waw_same_ack", md_ack, 1);
      next_cycle();
      w_valid = 1'b0; md_req = 1'b0; q_rs = 5'd12;
      #1;
      check("waw_same_busy", q_rs_busy, 0);
      check("waw_same_we", grf_we, 0);

      // Full FIFO backpressure
      next_cycle();
      w_valid = 1'b1; w_a3 = 5'd1;
      md_req = 1'b1; md_a3 = 5'd20; md_data = 32'd20;
      #1;
      check("full_ack1", md_ack, 1);
      next_cycle();
      md_a3 = 5'd21; md_data = 32'd21;
      #1;
      check("full_ack2", md_ack, 1);
      next_cycle();
      md_a3 = 5'd22; md_data = 32'd22;
      #1;
      check("full_hold_ack", md_ack, 0);
      next_cycle();
      w_valid = 1'b0;
      #1;
      check("full_pop_a3", grf_a3, 20);
      check("full_pop_ack", md_ack, 1);
      check("full_pop_stall", stall_req, 0);
      next_cycle();
      md_req = 1'b0;
      #1;
      check("full_drn2_a3", grf_a3, 21);
      next_cycle();
      #1;
      check("full_drn3_a3", grf_a3, 22);
      check("full_drn3_data", grf_md_data, 32'd22);
      next_cycle();
      #1;
      check("full_done_we", grf_we, 0);

      // Reset while in FORCE with two entries queued
      next_cycle();
      w_valid = 1'b1; w_a3 = 5'd1;
      md_req = 1'b1; md_a3 = 5'd14; md_data = 32'd14;
      next_cycle();
      md_a3 = 5'd15; md_data = 32'd15;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         md_req = 1'b0;
      end
      next_cycle();
      q_rs = 5'd14; q_rt = 5'd15;
      #1;
      check("rst2_force", stall_req, 1);
      check("rst2_rs_busy_before", q_rs_busy, 1);
      check("rst2_rt_busy_before", q_rt_busy, 1);
      reset = 1'b0;
      next_cycle();
      reset = 1'b1; w_valid = 1'b0;
      #1;
      check("rst2_stall", stall_req, 0);
      check("rst2_we", grf_we, 0);
      check("rst2_rs_busy", q_rs_busy, 0);
      check("rst2_rt_busy", q_rt_busy, 0);
      next_cycle();
      #1;
      check("rst2_no_write", grf_we, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
